// File: rtl/alarm_pkg.sv
// Shared encodings and digit-field layout for the alarm clock sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_RING   = 2'd1,
    R_SNOOZE = 2'd2
  } ring_e;

  localparam logic [3:0] SEP_NIB   = 4'hE;
  localparam logic [3:0] BLANK_NIB = 4'hF;

  localparam int unsigned HR_LSB  = 24;
  localparam int unsigned MIN_LSB = 12;
  localparam int unsigned SEC_LSB = 0;

  function automatic mode_e mode_step(input mode_e m);
    mode_e nxt;
    unique case (m)
      MODE_CLOCK:    nxt = MODE_SET_TIME;
      MODE_SET_TIME: nxt = MODE_SET_ALARM;
      default:       nxt = MODE_CLOCK;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alarm_ring_timer.sv
// Shared ms down-counter for ring/snooze durations, plus the free-running
// BEEP_MS phase toggle that paces the buzzer and the display flash.
module alarm_ring_timer #(
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned BEEP_MS = 250
) (
  input  logic             clk_1khz,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_phase_rst,
  output logic             o_zero,
  output logic             o_phase_on
);

  localparam int unsigned BeepW = (BEEP_MS > 1) ? $clog2(BEEP_MS) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [BeepW-1:0] r_beep_cnt;
  logic             r_phase;

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Raised on the cycle whose edge takes the count to zero: a load of N spans N cycles.
  assign o_zero = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_beep_cnt <= '0;
      r_phase    <= 1'b1;
    end else if (i_phase_rst) begin
      r_beep_cnt <= '0;
      r_phase    <= 1'b1;
    end else if (r_beep_cnt == BeepW'(BEEP_MS - 1)) begin
      r_beep_cnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_beep_cnt <= r_beep_cnt + 1'b1;
    end
  end

  assign o_phase_on = r_phase;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock top sequencer: mode FSM, display mux, alarm match and ring FSM.
// Define ALARM_SNOOZE_EN to build the snooze path.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_MS    = 60000,
`ifdef ALARM_SNOOZE_EN
  parameter int unsigned SNOOZE_MS  = 300000,
  parameter int unsigned SNOOZE_MAX = 3,
`endif
  parameter int unsigned BEEP_MS    = 250
) (
  input  logic        clk_1khz,
  input  logic        rst,
  input  logic        i_key_mode_p,
  input  logic        i_key_stop_p,
  input  logic        i_alarm_on,
  input  logic [31:0] i_time_bcd,
  input  logic [31:0] i_alarm_bcd,
  input  logic [31:0] i_tset_disp,
  input  logic [31:0] i_aset_disp,
  output logic        o_tset_en,
  output logic        o_aset_en,
  output logic [31:0] o_display_out,
  output logic        o_ringing,
  output logic        o_buzzer
);

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned CntMax = (RING_MS > SNOOZE_MS) ? RING_MS : SNOOZE_MS;
`else
  localparam int unsigned CntMax = RING_MS;
`endif
  localparam int unsigned CntW = $clog2(CntMax) + 1;

  mode_e            r_mode, w_mode_next;
  ring_e            r_ring_st, w_ring_next;
  logic             r_tset_en, r_aset_en, w_tset_next, w_aset_next;
  logic             r_match_d, w_match, w_trigger;
  logic             w_load, w_phase_rst, w_zero, w_phase_on;
  logic [CntW-1:0]  w_load_val;
  logic [31:0]      r_disp, w_disp_next;
  logic             w_unused;

  assign w_unused = ^{i_alarm_bcd[23:20], i_alarm_bcd[11:8]};

  assign w_match = i_alarm_on
                && (i_time_bcd[HR_LSB +: 8] == i_alarm_bcd[HR_LSB +: 8])
                && (i_time_bcd[MIN_LSB +: 8] == i_alarm_bcd[MIN_LSB +: 8])
                && (i_time_bcd[SEC_LSB +: 8] == 8'h00);
  assign w_trigger = w_match & ~r_match_d;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SnzW = ($clog2(SNOOZE_MAX + 1) < 2) ? 2 : $clog2(SNOOZE_MAX + 1);
  logic [SnzW-1:0] r_snooze_cnt;
  logic            w_snz_inc;

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_snooze_cnt <= '0;
    end else if (w_phase_rst) begin
      r_snooze_cnt <= '0;
    end else if (w_snz_inc) begin
      r_snooze_cnt <= r_snooze_cnt + 1'b1;
    end
  end
`endif

  // State registers
  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_mode    <= MODE_CLOCK;
      r_ring_st <= R_IDLE;
      r_tset_en <= 1'b0;
      r_aset_en <= 1'b0;
      r_match_d <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_mode    <= w_mode_next;
      r_ring_st <= w_ring_next;
      r_tset_en <= w_tset_next;
      r_aset_en <= w_aset_next;
      r_match_d <= w_match;
      r_disp    <= w_disp_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_mode_next = r_mode;
    if (i_key_mode_p && (r_ring_st == R_IDLE)) begin
      w_mode_next = mode_step(r_mode);
    end
  end

  always_comb begin
    w_ring_next = r_ring_st;
    w_load      = 1'b0;
    w_load_val  = CntW'(RING_MS);
    w_phase_rst = 1'b0;
`ifdef ALARM_SNOOZE_EN
    w_snz_inc   = 1'b0;
`endif
    unique case (r_ring_st)
      R_IDLE: begin
        if (w_trigger) begin
          w_ring_next = R_RING;
          w_load      = 1'b1;
          w_phase_rst = 1'b1;
        end
      end
      R_RING: begin
        if (!i_alarm_on || i_key_mode_p) begin
          w_ring_next = R_IDLE;
        end else if (i_key_stop_p) begin
`ifdef ALARM_SNOOZE_EN
          if (r_snooze_cnt < SnzW'(SNOOZE_MAX)) begin
            w_ring_next = R_SNOOZE;
            w_load      = 1'b1;
            w_load_val  = CntW'(SNOOZE_MS);
            w_snz_inc   = 1'b1;
          end else begin
            w_ring_next = R_IDLE;
          end
`else
          w_ring_next = R_IDLE;
`endif
        end else if (w_zero) begin
          w_ring_next = R_IDLE;
        end
      end
      R_SNOOZE: begin
        if (!i_alarm_on || i_key_mode_p || i_key_stop_p) begin
          w_ring_next = R_IDLE;
        end else if (w_zero) begin
          w_ring_next = R_RING;
          w_load      = 1'b1;
        end
      end
      default: w_ring_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_disp_next = i_time_bcd;
    if (r_ring_st == R_RING) begin
      if (!w_phase_on) begin
        w_disp_next = i_time_bcd | {8{BLANK_NIB}};
      end
    end else begin
      unique case (r_mode)
        MODE_SET_TIME:  w_disp_next = i_tset_disp;
        MODE_SET_ALARM: w_disp_next = i_aset_disp;
        default:        w_disp_next = i_time_bcd;
      endcase
    end
  end

  // Outputs
  always_comb begin
    w_tset_next   = (w_mode_next == MODE_SET_TIME);
    w_aset_next   = (w_mode_next == MODE_SET_ALARM);
    o_tset_en     = r_tset_en;
    o_aset_en     = r_aset_en;
    o_display_out = r_disp;
    o_ringing     = (r_ring_st == R_RING);
    o_buzzer      = (r_ring_st == R_RING) && w_phase_on;
  end

  alarm_ring_timer #(
    .CNT_W   (CntW),
    .BEEP_MS (BEEP_MS)
  ) u_timer (
    .clk_1khz    (clk_1khz),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .i_phase_rst (w_phase_rst),
    .o_zero      (w_zero),
    .o_phase_on  (w_phase_on)
  );

endmodule

// File: tb/tb_alarm_ctrl.sv
// Randomized and directed bench for alarm_ctrl against a cycle-level behavioural model.
module tb_alarm_ctrl;

  localparam int RING = 20;
  localparam int SNZ  = 50;
  localparam int SMAX = 2;
  localparam int BEEP = 4;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_BUILD = 1'b1;
`else
  localparam bit SNOOZE_BUILD = 1'b0;
`endif

  logic        clk_1khz = 1'b0;
  logic        rst = 1'b1;
  logic        key_mode_p = 1'b0, key_stop_p = 1'b0, alarm_on = 1'b0;
  logic [31:0] time_bcd = '0, alarm_bcd = '0, tset_disp = '0, aset_disp = '0;
  logic        tset_en, aset_en, ringing, buzzer;
  logic [31:0] display_out;

  always #5 clk_1khz = ~clk_1khz;

  alarm_ctrl #(
    .RING_MS    (RING),
`ifdef ALARM_SNOOZE_EN
    .SNOOZE_MS  (SNZ),
    .SNOOZE_MAX (SMAX),
`endif
    .BEEP_MS    (BEEP)
  ) dut (
    .clk_1khz      (clk_1khz),
    .rst           (rst),
    .i_key_mode_p  (key_mode_p),
    .i_key_stop_p  (key_stop_p),
    .i_alarm_on    (alarm_on),
    .i_time_bcd    (time_bcd),
    .i_alarm_bcd   (alarm_bcd),
    .i_tset_disp   (tset_disp),
    .i_aset_disp   (aset_disp),
    .o_tset_en     (tset_en),
    .o_aset_en     (aset_en),
    .o_display_out (display_out),
    .o_ringing     (ringing),
    .o_buzzer      (buzzer)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model: mode 0/1/2 = clock/set-time/set-alarm; ring 0/1/2 = idle/ring/snooze.
  int          m_mode = 0, m_ring = 0, m_el = 0, m_beep = 0, m_snz = 0;
  bit          m_match_d = 1'b0;
  logic [31:0] m_disp = '0;

  function automatic logic [31:0] bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'hE, 4'(m / 10), 4'(m % 10), 4'hE, 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit phase_on(input int t);
    return ((t / BEEP) % 2) == 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_step();
    bit mt, trig, ph;
    int nr;
    if (rst) begin
      m_mode = 0; m_ring = 0; m_el = 0; m_beep = 0; m_snz = 0; m_match_d = 0; m_disp = '0;
      return;
    end
    mt = alarm_on && (time_bcd[31:24] == alarm_bcd[31:24])
         && (time_bcd[19:12] == alarm_bcd[19:12]) && (time_bcd[7:0] == 8'h00);
    trig = mt && !m_match_d;
    ph = phase_on(m_beep);
    if (m_ring == 1)      m_disp = ph ? time_bcd : 32'hFFFF_FFFF;
    else if (m_mode == 1) m_disp = tset_disp;
    else if (m_mode == 2) m_disp = aset_disp;
    else                  m_disp = time_bcd;
    if (key_mode_p && m_ring == 0) m_mode = (m_mode + 1) % 3;
    m_match_d = mt;
    m_beep++;
    nr = m_ring;
    case (m_ring)
      0: if (trig) begin nr = 1; m_el = 0; m_beep = 0; m_snz = 0; end
      1: begin
        if (!alarm_on || key_mode_p) nr = 0;
        else if (key_stop_p) begin
          if (SNOOZE_BUILD && m_snz < SMAX) begin nr = 2; m_el = 0; m_snz++; end
          else nr = 0;
        end else if (m_el + 1 == RING) nr = 0;
        else m_el++;
      end
      default: begin
        if (!alarm_on || key_mode_p || key_stop_p) nr = 0;
        else if (m_el + 1 == SNZ) begin nr = 1; m_el = 0; end
        else m_el++;
      end
    endcase
    m_ring = nr;
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk_1khz);
    model_step();
    @(negedge clk_1khz);
    chk("ringing", 32'(ringing), 32'(m_ring == 1));
    chk("buzzer", 32'(buzzer), 32'(m_ring == 1 && phase_on(m_beep)));
    chk("display_out", display_out, m_disp);
    chk("tset_en", 32'(tset_en), 32'(m_mode == 1));
    chk("aset_en", 32'(aset_en), 32'(m_mode == 2));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_mode();
    key_mode_p = 1'b1; step(); key_mode_p = 1'b0;
  endtask

  task automatic pulse_stop();
    key_stop_p = 1'b1; step(); key_stop_p = 1'b0;
  endtask

  task automatic retrig(input logic [31:0] a);
    time_bcd = {a[31:8], 8'h01}; step();
    time_bcd = a; step();
  endtask

  initial begin
    int ring_cycles;
    int r;
    time_bcd  = bcd(12, 0, 1);
    alarm_bcd = bcd(7, 30, 0);
    tset_disp = 32'h1234_5678;
    aset_disp = 32'h8765_4321;
    steps(3);
    chk("reset_display", display_out, 32'h0);
    chk("reset_ringing", 32'(ringing), 32'h0);
    rst = 1'b0;
    step();

    // Mode cycling
    pulse_mode();
    chk("lit_tset_after_1", {30'h0, tset_en, aset_en}, 32'h2);
    step();
    chk("lit_disp_tset", display_out, 32'h1234_5678);
    pulse_mode();
    chk("lit_aset_after_2", {30'h0, tset_en, aset_en}, 32'h1);
    step();
    chk("lit_disp_aset", display_out, 32'h8765_4321);
    pulse_mode();
    chk("lit_clock_after_3", {30'h0, tset_en, aset_en}, 32'h0);
    step();
    chk("lit_disp_clock", display_out, bcd(12, 0, 1));

    // Ring and auto-dismiss
    alarm_on = 1'b1;
    time_bcd = bcd(7, 29, 59); step();
    time_bcd = bcd(7, 30, 0);  step();
    chk("lit_ring_start", 32'(ringing), 32'h1);
    chk("lit_buzz_start", 32'(buzzer), 32'h1);
    ring_cycles = 1;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (ringing) ring_cycles++;
      if (j == 1) chk("lit_disp_on", display_out, bcd(7, 30, 0));
      if (j == 5) begin
        chk("lit_disp_flash", display_out, 32'hFFFF_FFFF);
        chk("lit_buzz_off", 32'(buzzer), 32'h0);
      end
    end
    chk("lit_ring_len", 32'(ring_cycles), 32'(RING));
    steps(1000);
    chk("lit_no_retrigger", 32'(ringing), 32'h0);

    // Dismiss by mode key; both keys together
    retrig(alarm_bcd); steps(3);
    pulse_mode();
    chk("lit_dismiss", 32'(ringing), 32'h0);
    chk("lit_dismiss_mode", {30'h0, tset_en, aset_en}, 32'h0);
    steps(10);
    retrig(alarm_bcd); steps(2);
    key_mode_p = 1'b1; key_stop_p = 1'b1; step();
    key_mode_p = 1'b0; key_stop_p = 1'b0;
    chk("lit_both_keys", 32'(ringing), 32'h0);
    steps(60);
    chk("lit_both_keys_late", 32'(ringing), 32'h0);

    // Stop / snooze
    retrig(alarm_bcd); steps(2);
    pulse_stop();
    chk("lit_stop1", 32'(ringing), 32'h0);
`ifdef ALARM_SNOOZE_EN
    steps(SNZ - 1);
    chk("lit_snooze_quiet", 32'(ringing), 32'h0);
    step();
    chk("lit_rering1", 32'(ringing), 32'h1);
    steps(2);
    pulse_stop();
    chk("lit_stop2", 32'(ringing), 32'h0);
    steps(SNZ);
    chk("lit_rering2", 32'(ringing), 32'h1);
    pulse_stop();
    chk("lit_stop3", 32'(ringing), 32'h0);
`endif
    steps(60);
    chk("lit_stop_final", 32'(ringing), 32'h0);

    // alarm_on dropped mid-snooze, then midnight wrap
    retrig(alarm_bcd); steps(2);
    pulse_stop(); steps(5);
    alarm_on = 1'b0; step();
    time_bcd = bcd(7, 30, 1); step();
    alarm_on = 1'b1;
    steps(60);
    chk("lit_alarm_off", 32'(ringing), 32'h0);
    alarm_bcd = bcd(0, 0, 0);
    time_bcd = bcd(23, 59, 59); step();
    time_bcd = bcd(0, 0, 0);    step();
    chk("lit_midnight", 32'(ringing), 32'h1);

    // Reset mid-ring
    pulse_mode(); pulse_mode();
    retrig(alarm_bcd); steps(3);
    chk("lit_ring_in_set_time", {30'h0, ringing, tset_en}, 32'h3);
    rst = 1'b1;
    #1;
    chk("lit_rst_outs", {28'h0, ringing, buzzer, tset_en, aset_en}, 32'h0);
    chk("lit_rst_disp", display_out, 32'h0);
    steps(2);
    rst = 1'b0;
    step();
    chk("lit_mode_after_rst", {30'h0, tset_en, aset_en}, 32'h0);

    // Random traffic
    alarm_bcd = bcd(7, 30, 0);
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      time_bcd = alarm_bcd;
      else if (r < 20) time_bcd = {alarm_bcd[31:8], 8'h01};
      else if (r < 25) time_bcd = bcd(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                                      int'($urandom_range(0, 59)));
      key_mode_p = ($urandom_range(0, 29) == 0);
      key_stop_p = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) alarm_on = ~alarm_on;
      if ($urandom_range(0, 9) == 0) tset_disp = $urandom;
      if ($urandom_range(0, 9) == 0) aset_disp = $urandom;
      step();
    end
    key_mode_p = 1'b0;
    key_stop_p = 1'b0;
    steps(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
